fetch_queue: RTL and testbench
==============================

# fetch_queue

Instruction fetch queue between the program counter / instruction memory pair and the decode stage. It captures each fetched instruction together with the PC that addressed it, and buffers up to DEPTH entries so short decode stalls do not stop fetch. It drives the PC write-enable so the PC advances only when the queue can accept an entry. On a taken branch or jump it discards all wrong-path entries.

## Interface
- DEPTH, 4: queue entries; power of two, minimum 2.
- ADDR_W, 10: PC width; matches the PC output.
- DATA_W, 32: instruction word width.

- clock  input  1  rising-edge clock for all queue state.
- reset  input  1  asynchronous, active-high; clears the queue.
- enable  input  1  global run enable; low freezes all state.
- in_valid  input  1  in_pc/in_instr carry a valid fetch this cycle.
- in_pc  input  ADDR_W  PC currently presented to instruction memory.
- in_instr  input  DATA_W  instruction memory read data for in_pc.
- pc_write  output  1  write-enable to the PC; high lets the PC load its next value.
- flush  input  1  taken branch or jump resolved; discard the queue.
- out_valid  output  1  head entry valid.
- out_pc  output  ADDR_W  PC of the head entry.
- out_instr  output  DATA_W  instruction of the head entry.
- out_ready  input  1  decode accepts the head entry this cycle.
- count  output  $clog2(DEPTH)+1  number of occupied entries.

## Operation
- Storage is a circular buffer of DEPTH {pc, instr} entries with wr_ptr and rd_ptr, each $clog2(DEPTH) bits, plus a count register. Both pointers wrap modulo DEPTH.
- The following terms are combinational:
  - push = enable & in_valid & ~flush & (count < DEPTH)
  - pop = enable & out_valid & out_ready & ~flush
- pc_write = enable & ((count < DEPTH) | flush).
  - pc_write has no combinational path from out_ready.
  - During a flush, pc_write is high so the PC loads the branch or jump target.
- out_valid = (count != 0).
- out_pc and out_instr show the rd_ptr entry when count != 0, and drive 0 when the queue is empty. An instruction of 0 is a NOP.
- Register updates on each clock rising edge with enable high:
  - flush: wr_ptr, rd_ptr and count reset to 0. Flush overrides any push or pop in the same cycle; the wrong-path in_instr is dropped.
  - push only: write the entry at wr_ptr, increment wr_ptr, increment count.
  - pop only: increment rd_ptr, decrement count.
  - push and pop together: both pointers advance and count stays the same. This is legal at any count from 1 to DEPTH-1.
  - neither: hold.
- When full (count == DEPTH):
  - push and pc_write are low.
  - A pop in the same cycle frees one entry, but the push is not accepted until the next cycle.
- When empty: pop cannot occur because out_valid is low, whatever out_ready is.
- When enable is low: no register changes, pc_write is low, and flush is ignored. The outputs keep showing the held head entry.
- Reset, asserted at any time including mid-operation:
  - wr_ptr, rd_ptr and count clear to 0 immediately, without waiting for a clock edge.
  - Outputs go to: out_valid=0, out_pc=0, out_instr=0, count=0. pc_write follows enable, so it equals enable while reset is held.
  - Entry storage is not reset.

## Timing
- The PC updates on the falling clock edge and instruction memory read data is stable before the next rising edge, where the queue samples it.
- Latency from a push to visibility: an entry pushed at rising edge N appears on out_* after edge N. With an empty queue, out_valid rises one cycle after in_valid is accepted.
- Throughput is one entry per cycle in and one per cycle out. There are no bubbles at steady state when out_ready is held high.
- Flush at edge N: out_valid is 0 after edge N. The target instruction fetched in the next cycle appears after edge N+1.
- Reset deassertion: the first push can occur at the first rising edge after reset falls.

## Test plan
- Reset mid-run: with count=3, pulse reset between edges. Require count=0, out_valid=0 and out_instr=0 immediately, with no clock edge needed. The next push of pc=0x010 / instr=0x8C010004 appears at the head one edge later.
- Fill: hold out_ready=0 and push pcs 0,1,2,3.
  - After 4 edges: count=4, pc_write=0, and a 5th in_valid is ignored.
  - Set out_ready=1 for one cycle: head pc=1, count=3, pc_write=1.
- Steady stream: count=2 with in_valid=1 and out_ready=1 for 10 cycles. Require count to stay at 2, out_pc to increment by 1 each cycle, and order to be preserved.
- Wrap-around: push and pop 9 entries through DEPTH=4. Require pops in exact push order with correct {pc, instr} pairing across the pointer wrap.
- Flush: with count=4 and in_valid=1, assert flush.
  - During the flush cycle: pc_write=1.
  - After the edge: count=0 and out_valid=0.
  - Next cycle: push target pc=0x040, which appears at the head one edge later.
- Enable freeze: with count=2, drop enable for 3 cycles while toggling in_valid, out_ready and flush. Require count, head entry and pointers unchanged and pc_write=0. Raise enable and require normal operation to resume.

Source files
------------

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Purpose  : DEPTH-entry {pc, instr} circular buffer between fetch and decode.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     in_valid,
    input  logic [ADDR_W-1:0]        in_pc,
    input  logic [DATA_W-1:0]        in_instr,
    output logic                     pc_write,
    input  logic                     flush,
    output logic                     out_valid,
    output logic [ADDR_W-1:0]        out_pc,
    output logic [DATA_W-1:0]        out_instr,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] C_PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [ADDR_W-1:0] pc_mem    [DEPTH];
    logic [DATA_W-1:0] instr_mem [DEPTH];

    logic w_not_full;
    logic w_push;
    logic w_pop;

    assign w_not_full = (count_q < C_FULL);
    assign out_valid  = (count_q != '0);
    assign w_push     = enable & in_valid & ~flush & w_not_full;
    assign w_pop      = enable & out_valid & out_ready & ~flush;

    // Depends only on occupancy and flush, never on out_ready, so a pop in
    // a full cycle does not let the PC advance until the following cycle.
    assign pc_write   = enable & (w_not_full | flush);

    assign out_pc     = out_valid ? pc_mem[rd_ptr_q]    : '0;
    assign out_instr  = out_valid ? instr_mem[rd_ptr_q] : '0;
    assign count      = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (enable) begin
            if (flush) begin
                wr_ptr_d = '0;
                rd_ptr_d = '0;
                count_d  = '0;
            end else begin
                if (w_push) begin
                    wr_ptr_d = wr_ptr_q + C_PTR_ONE;
                end
                if (w_pop) begin
                    rd_ptr_d = rd_ptr_q + C_PTR_ONE;
                end
                case ({w_push, w_pop})
                    2'b10:   count_d = count_q + C_CNT_ONE;
                    2'b01:   count_d = count_q - C_CNT_ONE;
                    default: count_d = count_q;
                endcase
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage carries no reset; out_* are masked while empty.
    always_ff @(posedge clock) begin
        if (w_push) begin
            pc_mem[wr_ptr_q]    <= in_pc;
            instr_mem[wr_ptr_q] <= in_instr;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_queue
// Purpose  : Directed self-checking bench for fetch_queue (DEPTH=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic        in_valid;
    logic [9:0]  in_pc;
    logic [31:0] in_instr;
    logic        pc_write;
    logic        flush;
    logic        out_valid;
    logic [9:0]  out_pc;
    logic [31:0] out_instr;
    logic        out_ready;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    fetch_queue #(.DEPTH(4), .ADDR_W(10), .DATA_W(32)) dut (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .in_valid  (in_valid),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .pc_write  (pc_write),
        .flush     (flush),
        .out_valid (out_valid),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .out_ready (out_ready),
        .count     (count)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] instr_of(input logic [9:0] pc);
        return 32'hA500_0000 | {22'd0, pc};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_push(input logic [9:0] pc);
        in_valid = 1'b1;
        in_pc    = pc;
        in_instr = instr_of(pc);
    endtask

    task automatic idle();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic drain();
        idle();
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        out_ready = 1'b0;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL drain_count: got %0d expected 0", count); end
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; idle(); in_pc = '0; in_instr = '0;
        #1;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL rst_count: got %0d expected 0", count); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_pc !== 10'd0) begin errors++; $display("FAIL rst_out_pc: got %h expected 0", out_pc); end
        checks++; if (out_instr !== 32'd0) begin errors++; $display("FAIL rst_out_instr: got %h expected 0", out_instr); end
        checks++; if (pc_write !== 1'b1) begin errors++; $display("FAIL rst_pc_write: got %b expected 1", pc_write); end
        tick();
        #2 reset = 1'b0;
        out_ready = 1'b1;
        tick();
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL empty_pop_count: got %0d expected 0", count); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL empty_pop_valid: got %b expected 0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            drive_push(10'(i + 5));
            tick();
        end
        in_valid = 1'b0;
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL mid_pre_count: got %0d expected 3", count); end
        #2 reset = 1'b1;
        #1;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL mid_count: got %0d expected 0", count); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b expected 0", out_valid); end
        checks++; if (out_instr !== 32'd0) begin errors++; $display("FAIL mid_instr: got %h expected 0", out_instr); end
        #1 reset = 1'b0;
        in_valid = 1'b1; in_pc = 10'h010; in_instr = 32'h8C01_0004;
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_push_valid: got %b expected 1", out_valid); end
        checks++; if (out_pc !== 10'h010) begin errors++; $display("FAIL mid_push_pc: got %h expected 010", out_pc); end
        checks++; if (out_instr !== 32'h8C01_0004) begin errors++; $display("FAIL mid_push_instr: got %h expected 8c010004", out_instr); end
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL mid_push_count: got %0d expected 1", count); end
        drain();
    endtask

    task automatic test_fill();
        idle();
        for (int i = 0; i < 4; i++) begin
            drive_push(10'(i));
            tick();
        end
        drive_push(10'd4);
        #1;
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_count: got %0d expected 4", count); end
        checks++; if (pc_write !== 1'b0) begin errors++; $display("FAIL fill_pc_write: got %b expected 0", pc_write); end
        tick();
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_ignore_count: got %0d expected 4", count); end
        checks++; if (out_pc !== 10'd0) begin errors++; $display("FAIL fill_head_pc: got %h expected 0", out_pc); end
        drive_push(10'd5);
        out_ready = 1'b1;
        #1;
        checks++; if (pc_write !== 1'b0) begin errors++; $display("FAIL full_pop_pc_write: got %b expected 0", pc_write); end
        tick();
        idle();
        #1;
        checks++; if (out_pc !== 10'd1) begin errors++; $display("FAIL fill_pop_pc: got %h expected 1", out_pc); end
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL fill_pop_count: got %0d expected 3", count); end
        checks++; if (pc_write !== 1'b1) begin errors++; $display("FAIL fill_pop_pc_write: got %b expected 1", pc_write); end
        out_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            checks++; if (out_pc !== 10'(i) || out_instr !== instr_of(10'(i)))
                begin errors++; $display("FAIL fill_drain_%0d: got %h/%h expected %h/%h", i, out_pc, out_instr, 10'(i), instr_of(10'(i))); end
            tick();
        end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL fill_no_overflow: got %0d expected 0", count); end
        idle();
    endtask

    task automatic test_back_to_back();
        idle();
        drive_push(10'h020); tick();
        drive_push(10'h021); tick();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive_push(10'(10'h022 + i));
            tick();
            checks++; if (count !== 3'd2) begin errors++; $display("FAIL stream_count_%0d: got %0d expected 2", i, count); end
            checks++; if (out_pc !== 10'(10'h021 + i) || out_instr !== instr_of(10'(10'h021 + i)))
                begin errors++; $display("FAIL stream_head_%0d: got %h/%h expected %h", i, out_pc, out_instr, 10'(10'h021 + i)); end
        end
        drain();
    endtask

    task automatic test_wrap();
        logic [9:0] model [$];
        int pushed = 0;
        int popped = 0;
        logic do_push;
        idle();
        for (int c = 0; c < 24; c++) begin
            in_valid  = (pushed < 9);
            in_pc     = 10'(10'h100 + pushed * 3);
            in_instr  = instr_of(in_pc);
            out_ready = (c % 3 != 0);
            #1;
            checks++; if (count !== 3'(model.size())) begin errors++; $display("FAIL wrap_count_%0d: got %0d expected %0d", c, count, model.size()); end
            if (model.size() != 0) begin
                checks++; if (out_pc !== model[0] || out_instr !== instr_of(model[0]))
                    begin errors++; $display("FAIL wrap_head_%0d: got %h/%h expected %h/%h", c, out_pc, out_instr, model[0], instr_of(model[0])); end
            end
            do_push = in_valid && (model.size() < 4);
            if (out_ready && model.size() != 0) begin
                void'(model.pop_front());
                popped++;
            end
            if (do_push) begin
                model.push_back(in_pc);
                pushed++;
            end
            tick();
        end
        idle();
        checks++; if (popped !== 9) begin errors++; $display("FAIL wrap_popped: got %0d expected 9", popped); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL wrap_final_count: got %0d expected 0", count); end
    endtask

    task automatic test_flush();
        idle();
        for (int i = 0; i < 4; i++) begin
            drive_push(10'(10'h030 + i));
            tick();
        end
        drive_push(10'h03F);
        flush = 1'b1;
        out_ready = 1'b1;
        #1;
        checks++; if (pc_write !== 1'b1) begin errors++; $display("FAIL flush_pc_write: got %b expected 1", pc_write); end
        tick();
        flush = 1'b0; out_ready = 1'b0;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL flush_count: got %0d expected 0", count); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b expected 0", out_valid); end
        drive_push(10'h040);
        tick();
        in_valid = 1'b0;
        checks++; if (out_pc !== 10'h040 || out_instr !== instr_of(10'h040))
            begin errors++; $display("FAIL flush_target: got %h/%h expected 040/%h", out_pc, out_instr, instr_of(10'h040)); end
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL flush_target_count: got %0d expected 1", count); end
        drain();
    endtask

    task automatic test_enable_freeze();
        idle();
        drive_push(10'h04F); tick();
        drive_push(10'h050); out_ready = 1'b1; tick();
        drive_push(10'h051); out_ready = 1'b0; tick();
        in_valid = 1'b0;
        checks++; if (count !== 3'd2 || out_pc !== 10'h050) begin errors++; $display("FAIL freeze_pre: got %0d/%h expected 2/050", count, out_pc); end
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid  = (i != 1);
            in_pc     = 10'(10'h3A0 + i);
            in_instr  = 32'hDEAD_0000;
            out_ready = (i != 2);
            flush     = (i == 1);
            #1;
            checks++; if (pc_write !== 1'b0) begin errors++; $display("FAIL freeze_pc_write_%0d: got %b expected 0", i, pc_write); end
            tick();
            checks++; if (count !== 3'd2 || out_pc !== 10'h050 || out_instr !== instr_of(10'h050))
                begin errors++; $display("FAIL freeze_hold_%0d: got %0d/%h/%h expected 2/050", i, count, out_pc, out_instr); end
        end
        enable = 1'b1; flush = 1'b0;
        drive_push(10'h052); out_ready = 1'b1;
        tick();
        checks++; if (count !== 3'd2 || out_pc !== 10'h051) begin errors++; $display("FAIL resume_1: got %0d/%h expected 2/051", count, out_pc); end
        in_valid = 1'b0;
        tick();
        checks++; if (count !== 3'd1 || out_pc !== 10'h052 || out_instr !== instr_of(10'h052))
            begin errors++; $display("FAIL resume_2: got %0d/%h/%h expected 1/052", count, out_pc, out_instr); end
        drain();
    endtask

    initial begin
        test_reset();
        test_reset_mid();
        test_fill();
        test_back_to_back();
        test_wrap();
        test_flush();
        test_enable_freeze();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
